// File: rtl/instr_fetch_queue.sv
// Fetch queue between the PC and decode: issues in-order imem requests,
// tracks them with a tag queue and buffers {instr, pc} pairs for decode.
module instr_fetch_queue #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 4,
    parameter int MAX_OUT = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           pc,
    input  logic                       pc_valid,
    output logic                       pc_stall,
    input  logic                       flush,
    output logic                       imem_req,
    output logic [WIDTH-1:0]           imem_addr,
    input  logic                       imem_gnt,
    input  logic                       imem_rvalid,
    input  logic [31:0]                imem_rdata,
    output logic                       instr_valid,
    input  logic                       instr_ready,
    output logic [31:0]                instr,
    output logic [WIDTH-1:0]           instr_pc,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(MAX_OUT + 1);
    localparam int TW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

    logic [OW-1:0]    outstanding;
    logic [OW-1:0]    discard;
    logic [WIDTH-1:0] tag_q [MAX_OUT];
    logic [TW-1:0]    tag_wr;
    logic [TW-1:0]    tag_rd;
    logic [31:0]      fifo_instr [DEPTH];
    logic [WIDTH-1:0] fifo_pc [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    logic [CW:0] credit_sum;
    logic        space;
    logic        issue;
    logic        rsp;
    logic        push;
    logic        pop;

    // Credit check, handshakes and head-of-queue outputs.
    always_comb begin
        credit_sum  = (CW+1)'(outstanding) + (CW+1)'(count);
        space       = (credit_sum < (CW+1)'(DEPTH))
                   && (outstanding < OW'(MAX_OUT));
        imem_req    = pc_valid && space && !flush;
        imem_addr   = pc;
        issue       = imem_req && imem_gnt;
        pc_stall    = pc_valid && !issue;
        rsp         = imem_rvalid && (outstanding != '0);
        push        = rsp && (discard == '0) && !flush;
        instr_valid = (count != '0) && !flush;
        pop         = instr_valid && instr_ready;
        instr       = fifo_instr[rd_ptr];
        instr_pc    = fifo_pc[rd_ptr];
    end

    // Outstanding-request, discard and sticky error bookkeeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outstanding <= '0;
            discard     <= '0;
            err         <= 1'b0;
        end else begin
            unique case ({issue, rsp})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
            if (flush) begin
                discard <= outstanding - OW'(rsp);
            end else if (rsp && (discard != '0)) begin
                discard <= discard - 1'b1;
            end
            if (imem_rvalid && (outstanding == '0)) begin
                err <= 1'b1;
            end
        end
    end

    // Tag queue holding the PC of each in-flight request, in order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_wr <= '0;
            tag_rd <= '0;
            for (int i = 0; i < MAX_OUT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            if (issue) begin
                tag_q[tag_wr] <= pc;
                tag_wr <= (tag_wr == TW'(MAX_OUT - 1)) ? '0 : tag_wr + 1'b1;
            end
            if (rsp) begin
                tag_rd <= (tag_rd == TW'(MAX_OUT - 1)) ? '0 : tag_rd + 1'b1;
            end
        end
    end

    // Instruction FIFO; a flush empties it at the end of the cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_instr[i] <= '0;
                fifo_pc[i]    <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo_instr[wr_ptr] <= imem_rdata;
                fifo_pc[wr_ptr]    <= tag_q[tag_rd];
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule
